// File: rtl/autoconfig_host_if.sv
// Zorro II address/strobe bundle between the Autoconfig initiator and the
// boards it configures. The bidirectional data nibble stays a top-level port.
interface autoconfig_host_if;
    logic [23:1] ADDR;
    logic        ASn;
    logic        UDSn;
    logic        LDSn;
    logic        RWn;

    modport master (output ADDR, ASn, UDSn, LDSn, RWn);
    modport slave  (input  ADDR, ASn, UDSn, LDSn, RWn);
endinterface

// File: rtl/autoconfig_host.sv
// Zorro II Autoconfig initiator. After a start pulse it walks the config
// chain at $E80000, reads each board's type/size/manufacturer nibbles and
// either maps memory boards first-fit into $200000-$9FFFFF or shuts them up.
module autoconfig_host #(
    parameter int STRB_CLKS  = 4,
    parameter int MAX_BOARDS = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    autoconfig_host_if.master        bus,
    inout  wire  [3:0]               DBUS,
    output logic                     CFGOUTn,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [3:0]               board_count,
    output logic [7:0]               mem_map
);

    localparam int CNT_W  = $clog2(STRB_CLKS + 1);
    localparam int ITER_W = $clog2(MAX_BOARDS + 1);

    typedef enum logic [1:0] {B_IDLE, B_SETUP, B_STRB, B_RECOV} bstate_t;
    typedef enum logic [3:0] {
        M_IDLE, M_RD_TYPE, M_RD_SIZE, M_RD_MFG, M_CHECK, M_DECIDE,
        M_WR_LO, M_WR_HI, M_WR_SHUT, M_NEXT, M_FINISH
    } mstate_t;

    bstate_t            bstate, bstate_nxt;
    mstate_t            state, state_nxt;

    logic [CNT_W-1:0]   strb_cnt;
    logic [22:0]        addr_r;
    logic               wr_r;
    logic [3:0]         wdata_r;
    logic [3:0]         rdata_r;
    logic               strb_last;
    logic               bus_last;

    logic               bus_go;
    logic               bus_wr;
    logic [7:0]         bus_idx;
    logic [3:0]         bus_wdata;

    logic [3:1]         type_r;
    logic [2:0]         size_r;
    logic [3:0]         mfg_raw [4];
    logic [1:0]         mfg_idx;
    logic [ITER_W-1:0]  iter_cnt;
    logic               iter_last;
    logic               cfg_en;
    logic [2:0]         alloc_k;
    logic [7:0]         alloc_mask;

    logic [3:0]         size_mb;
    logic               accept;
    logic               slot_found;
    logic [2:0]         slot_k;
    logic [7:0]         slot_mask;

    // Contiguous run of n one-megabyte slots starting at slot 0.
    function automatic logic [7:0] window_mask(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h03;
            4'd4:    return 8'h0F;
            4'd8:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    // Board counter sticks at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign strb_last = (strb_cnt == CNT_W'(STRB_CLKS - 1));
    assign bus_last  = (bstate == B_RECOV);
    assign iter_last = (iter_cnt == ITER_W'(MAX_BOARDS - 1));

    // Bus outputs decode straight from the bus state so a reset lands them idle on the next edge.
    assign bus.ADDR  = (bstate != B_IDLE) ? addr_r : 23'd0;
    assign bus.ASn   = (bstate != B_STRB);
    assign bus.UDSn  = (bstate != B_STRB);
    assign bus.LDSn  = 1'b1;
    assign bus.RWn   = (bstate != B_IDLE) ? ~wr_r : 1'b1;
    assign DBUS      = ((bstate != B_IDLE) && wr_r) ? wdata_r : 4'bz;

    assign CFGOUTn     = ~cfg_en;
    assign busy        = (state != M_IDLE) && (state != M_FINISH);
    assign done        = (state == M_FINISH);

    // Bus cycle state register.
    always_ff @(posedge CLK) begin
        if (RESET) bstate <= B_IDLE;
        else       bstate <= bstate_nxt;
    end

    // Bus cycle sequencing: setup, STRB_CLKS of strobe, one recovery clock.
    always_comb begin
        bstate_nxt = bstate;
        case (bstate)
            B_IDLE:  if (bus_go) bstate_nxt = B_SETUP;
            B_SETUP: bstate_nxt = B_STRB;
            B_STRB:  if (strb_last) bstate_nxt = B_RECOV;
            B_RECOV: bstate_nxt = B_IDLE;
            default: bstate_nxt = B_IDLE;
        endcase
    end

    // Bus datapath: latch the request at launch, count strobe clocks, sample read data on the last one.
    always_ff @(posedge CLK) begin
        if (bstate == B_IDLE && bus_go) begin
            addr_r  <= 23'h740000 | {15'd0, bus_idx};
            wr_r    <= bus_wr;
            wdata_r <= bus_wdata;
        end
        if (bstate == B_SETUP) strb_cnt <= '0;
        else if (bstate == B_STRB) strb_cnt <= strb_cnt + 1'b1;
        if (bstate == B_STRB && strb_last) rdata_r <= DBUS;
    end

    // Scan state register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= M_IDLE;
        else       state <= state_nxt;
    end

    // Scan sequencing and bus requests; each bus state advances when its cycle recovers.
    always_comb begin
        state_nxt = state;
        bus_go    = 1'b0;
        bus_wr    = 1'b0;
        bus_idx   = 8'h00;
        bus_wdata = 4'h0;
        case (state)
            M_IDLE:    if (start) state_nxt = M_RD_TYPE;
            M_RD_TYPE: begin
                bus_go  = (bstate == B_IDLE);
                bus_idx = 8'h00;
                if (bus_last) state_nxt = M_RD_SIZE;
            end
            M_RD_SIZE: begin
                bus_go  = (bstate == B_IDLE);
                bus_idx = 8'h01;
                if (bus_last) state_nxt = M_RD_MFG;
            end
            M_RD_MFG: begin
                bus_go  = (bstate == B_IDLE);
                bus_idx = 8'h08 + {6'd0, mfg_idx};
                if (bus_last && mfg_idx == 2'd3) state_nxt = M_CHECK;
            end
            M_CHECK: begin
                if (mfg_raw[0] == 4'hF && mfg_raw[1] == 4'hF &&
                    mfg_raw[2] == 4'hF && mfg_raw[3] == 4'hF) state_nxt = M_FINISH;
                else state_nxt = M_DECIDE;
            end
            M_DECIDE:  state_nxt = (accept && slot_found) ? M_WR_LO : M_WR_SHUT;
            M_WR_LO: begin
                bus_go  = (bstate == B_IDLE);
                bus_wr  = 1'b1;
                bus_idx = 8'h25;
                if (bus_last) state_nxt = M_WR_HI;
            end
            M_WR_HI: begin
                bus_go    = (bstate == B_IDLE);
                bus_wr    = 1'b1;
                bus_idx   = 8'h24;
                bus_wdata = {1'b0, alloc_k} + 4'd2;
                if (bus_last) state_nxt = M_NEXT;
            end
            M_WR_SHUT: begin
                bus_go  = (bstate == B_IDLE);
                bus_wr  = 1'b1;
                bus_idx = 8'h26;
                if (bus_last) state_nxt = M_NEXT;
            end
            M_NEXT:    state_nxt = iter_last ? M_FINISH : M_RD_TYPE;
            M_FINISH:  state_nxt = M_FINISH;
            default:   state_nxt = M_IDLE;
        endcase
    end

    // Board qualification and first-fit slot search; scanning downward leaves the lowest aligned free k.
    always_comb begin
        case (size_r)
            3'b000:  size_mb = 4'd8;
            3'b111:  size_mb = 4'd4;
            3'b110:  size_mb = 4'd2;
            3'b101:  size_mb = 4'd1;
            default: size_mb = 4'd0;
        endcase
        accept     = (type_r[3:2] == 2'b11) && type_r[1] && (size_mb != 4'd0);
        slot_found = 1'b0;
        slot_k     = 3'd0;
        slot_mask  = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            if (size_mb != 4'd0 && (k[3:0] & (size_mb - 4'd1)) == 4'd0 &&
                (k + int'(size_mb)) <= 8 &&
                (mem_map & (window_mask(size_mb) << k)) == 8'h00) begin
                slot_found = 1'b1;
                slot_k     = 3'(k);
                slot_mask  = window_mask(size_mb) << k;
            end
        end
    end

    // Scan bookkeeping: captured nibbles, allocation result, map/count/iteration updates.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cfg_en      <= 1'b0;
            error       <= 1'b0;
            board_count <= 4'd0;
            mem_map     <= 8'h00;
            iter_cnt    <= '0;
            mfg_idx     <= 2'd0;
        end else begin
            if (state == M_IDLE && start) begin
                cfg_en   <= 1'b1;
                iter_cnt <= '0;
                mfg_idx  <= 2'd0;
            end
            if (bus_last) begin
                case (state)
                    M_RD_TYPE: type_r <= rdata_r[3:1];
                    M_RD_SIZE: size_r <= rdata_r[2:0];
                    M_RD_MFG: begin
                        mfg_raw[mfg_idx] <= rdata_r;
                        mfg_idx          <= mfg_idx + 2'd1;
                    end
                    M_WR_HI: begin
                        mem_map     <= mem_map | alloc_mask;
                        board_count <= sat_inc(board_count);
                    end
                    default: ;
                endcase
            end
            if (state == M_DECIDE) begin
                alloc_k    <= slot_k;
                alloc_mask <= slot_mask;
            end
            if (state == M_NEXT) begin
                iter_cnt <= iter_cnt + 1'b1;
                if (iter_last) error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: a behavioural chain of Autoconfig boards answers
// reads on DBUS, advances on $24/$26 writes, and every bus cycle is logged.
module tb_autoconfig_host;

    localparam int STRB_CLKS  = 4;
    localparam int MAX_BOARDS = 8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    wire  [3:0] DBUS;
    logic       CFGOUTn, busy, done, error;
    logic [3:0] board_count;
    logic [7:0] mem_map;

    int n_checks = 0;
    int n_errors = 0;

    autoconfig_host_if bus();

    autoconfig_host #(.STRB_CLKS(STRB_CLKS), .MAX_BOARDS(MAX_BOARDS)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .bus(bus), .DBUS(DBUS),
        .CFGOUTn(CFGOUTn), .busy(busy), .done(done), .error(error),
        .board_count(board_count), .mem_map(mem_map)
    );

    always #5 CLK = ~CLK;

    // Board chain model
    logic [3:0]  b_type [4];
    logic [3:0]  b_size [4];
    logic [15:0] b_mfg  [4];
    int          n_boards = 0;
    int          cur = 0;
    bit          sticky = 1'b0;
    logic [7:0]  reg_idx;
    logic [3:0]  rd_nib;
    logic [1:0]  ci;

    assign reg_idx = bus.ADDR[8:1];
    assign ci      = cur[1:0];

    always_comb begin
        rd_nib = 4'hF;
        if (cur < n_boards) begin
            case (reg_idx)
                8'h00:   rd_nib = b_type[ci];
                8'h01:   rd_nib = b_size[ci];
                8'h08:   rd_nib = ~b_mfg[ci][15:12];
                8'h09:   rd_nib = ~b_mfg[ci][11:8];
                8'h0A:   rd_nib = ~b_mfg[ci][7:4];
                8'h0B:   rd_nib = ~b_mfg[ci][3:0];
                default: rd_nib = 4'hF;
            endcase
        end
    end

    assign DBUS = bus.RWn ? rd_nib : 4'bz;

    // Bus monitor
    bit         log_wr  [$];
    logic [7:0] log_idx [$];
    logic [3:0] log_dat [$];
    int         strb_run = 0, strb_min = 999, strb_max = 0;
    int         base_bad = 0, uds_bad = 0, early_bad = 0;
    logic       as_prev = 1'b1, wr_prev = 1'b0;
    logic [3:0] dbus_prev = 4'h0;

    always @(negedge CLK) begin
        if (bus.ASn !== bus.UDSn || bus.LDSn !== 1'b1) uds_bad++;
        if (!bus.ASn && as_prev) begin
            log_wr.push_back(!bus.RWn);
            log_idx.push_back(reg_idx);
            log_dat.push_back(DBUS);
            if (bus.ADDR[23:9] != 15'h7400) base_bad++;
            if (!bus.RWn && (!wr_prev || dbus_prev !== DBUS)) early_bad++;
            if (!bus.RWn && !sticky && (reg_idx == 8'h24 || reg_idx == 8'h26)) cur++;
        end
        if (!bus.ASn) strb_run++;
        else if (strb_run > 0) begin
            if (strb_run < strb_min) strb_min = strb_run;
            if (strb_run > strb_max) strb_max = strb_run;
            strb_run = 0;
        end
        as_prev   = bus.ASn;
        wr_prev   = !bus.RWn;
        dbus_prev = DBUS;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_wr.delete(); log_idx.delete(); log_dat.delete();
        strb_min = 999; strb_max = 0;
        base_bad = 0; uds_bad = 0; early_bad = 0;
        cur = 0;
    endtask

    task automatic do_reset(input string tag);
        RESET = 1'b1; start = 1'b0;
        repeat (2) @(negedge CLK);
        chk({tag, "_rst_asn"},  bus.ASn, 1'b1);
        chk({tag, "_rst_rwn"},  bus.RWn, 1'b1);
        chk({tag, "_rst_addr"}, bus.ADDR, 23'd0);
        chk({tag, "_rst_cfg"},  CFGOUTn, 1'b1);
        chk({tag, "_rst_flags"}, {busy, done, error}, 3'b000);
        chk({tag, "_rst_cnt"},  board_count, 4'd0);
        chk({tag, "_rst_map"},  mem_map, 8'h00);
        RESET = 1'b0;
        @(negedge CLK);
        clear_log();
    endtask

    task automatic set_board(input int b, input logic [3:0] t, input logic [3:0] s, input logic [15:0] m);
        b_type[b] = t; b_size[b] = s; b_mfg[b] = m;
    endtask

    task automatic run_scan(input string tag);
        int n;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_strb_len"}, {strb_min[7:0], strb_max[7:0]}, {8'(STRB_CLKS), 8'(STRB_CLKS)});
        chk({tag, "_bus_form"}, base_bad + uds_bad + early_bad, 0);
    endtask

    // Expected write sequence, filled before calling chk_writes.
    logic [7:0] wexp_idx [$];
    logic [3:0] wexp_dat [$];

    task automatic chk_writes(input string tag);
        logic [7:0] ai [$];
        logic [3:0] ad [$];
        for (int i = 0; i < log_wr.size(); i++)
            if (log_wr[i]) begin ai.push_back(log_idx[i]); ad.push_back(log_dat[i]); end
        chk({tag, "_nwrites"}, ai.size(), wexp_idx.size());
        for (int i = 0; i < ai.size() && i < wexp_idx.size(); i++) begin
            chk($sformatf("%s_w%0d_idx", tag, i), ai[i], wexp_idx[i]);
            chk($sformatf("%s_w%0d_dat", tag, i), ad[i], wexp_dat[i]);
        end
        wexp_idx.delete(); wexp_dat.delete();
    endtask

    function automatic int count_reads();
        int c = 0;
        for (int i = 0; i < log_wr.size(); i++) if (!log_wr[i]) c++;
        return c;
    endfunction

    initial begin
        logic [7:0] rd_exp [6];
        int n, lsz;
        rd_exp[0] = 8'h00; rd_exp[1] = 8'h01; rd_exp[2] = 8'h08;
        rd_exp[3] = 8'h09; rd_exp[4] = 8'h0A; rd_exp[5] = 8'h0B;
        RESET = 1'b1; start = 1'b0;

        // Empty chain: six reads, no writes
        do_reset("t1");
        n_boards = 0; sticky = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("t1_busy_early", busy, 1'b1);
        chk("t1_cfgout_low", CFGOUTn, 1'b0);
        n = 0;
        while (!done && n < 3000) begin @(negedge CLK); n++; end
        chk("t1_done", done, 1'b1);
        chk("t1_nlog", log_wr.size(), 6);
        for (int i = 0; i < 6 && i < log_wr.size(); i++) begin
            chk($sformatf("t1_r%0d_idx", i), log_idx[i], rd_exp[i]);
            chk($sformatf("t1_r%0d_wr", i), log_wr[i], 1'b0);
        end
        chk("t1_cnt", board_count, 4'd0);
        chk("t1_map", mem_map, 8'h00);
        chk("t1_err", error, 1'b0);
        chk("t1_cfgout", CFGOUTn, 1'b0);
        chk("t1_strb_len", strb_max, STRB_CLKS);
        // start while done must be ignored
        lsz = log_wr.size();
        start = 1'b1; @(negedge CLK); start = 1'b0;
        repeat (20) @(negedge CLK);
        chk("t1_restart_ignored", log_wr.size(), lsz);
        chk("t1_done_held", {done, busy}, 2'b10);

        // One 8 MB board
        do_reset("t2");
        n_boards = 1;
        set_board(0, 4'hE, 4'h0, 16'h07DB);
        run_scan("t2");
        wexp_idx = '{8'h25, 8'h24}; wexp_dat = '{4'h0, 4'h2};
        chk_writes("t2");
        chk("t2_reads", count_reads(), 12);
        chk("t2_map", mem_map, 8'hFF);
        chk("t2_cnt", board_count, 4'd1);
        chk("t2_err", error, 1'b0);

        // 2 MB then 4 MB board
        do_reset("t3");
        n_boards = 2;
        set_board(0, 4'hE, 4'h6, 16'h07DB);
        set_board(1, 4'hE, 4'h7, 16'h0202);
        run_scan("t3");
        wexp_idx = '{8'h25, 8'h24, 8'h25, 8'h24}; wexp_dat = '{4'h0, 4'h2, 4'h0, 4'h6};
        chk_writes("t3");
        chk("t3_map", mem_map, 8'hF3);
        chk("t3_cnt", board_count, 4'd2);

        // 8 MB fills the window; 1 MB board and an I/O board get shut up
        do_reset("t4");
        n_boards = 3;
        set_board(0, 4'hE, 4'h0, 16'h07DB);
        set_board(1, 4'hE, 4'h5, 16'h0202);
        set_board(2, 4'hC, 4'h5, 16'h1234);
        run_scan("t4");
        wexp_idx = '{8'h25, 8'h24, 8'h26, 8'h26}; wexp_dat = '{4'h0, 4'h2, 4'h0, 4'h0};
        chk_writes("t4");
        chk("t4_map", mem_map, 8'hFF);
        chk("t4_cnt", board_count, 4'd1);
        chk("t4_err", error, 1'b0);

        // Board that never leaves the chain: iteration limit
        do_reset("t5");
        n_boards = 1; sticky = 1'b1;
        set_board(0, 4'hE, 4'h0, 16'h07DB);
        run_scan("t5");
        wexp_idx = '{8'h25, 8'h24, 8'h26, 8'h26, 8'h26, 8'h26, 8'h26, 8'h26, 8'h26};
        wexp_dat = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        chk_writes("t5");
        chk("t5_reads", count_reads(), 6 * MAX_BOARDS);
        chk("t5_err", error, 1'b1);
        chk("t5_cnt", board_count, 4'd1);
        sticky = 1'b0;

        // Reset in the middle of the WR_HI strobe, then a clean rescan
        do_reset("t6");
        n_boards = 1;
        set_board(0, 4'hE, 4'h0, 16'h07DB);
        start = 1'b1; @(negedge CLK); start = 1'b0;
        n = 0;
        while (!(!bus.ASn && !bus.RWn && reg_idx == 8'h24) && n < 3000) begin
            @(negedge CLK); n++;
        end
        chk("t6_reached_wrhi", n < 3000, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        chk("t6_asn", {bus.ASn, bus.UDSn}, 2'b11);
        chk("t6_rwn", bus.RWn, 1'b1);
        chk("t6_addr", bus.ADDR, 23'd0);
        chk("t6_cfg", CFGOUTn, 1'b1);
        chk("t6_map", mem_map, 8'h00);
        chk("t6_flags", {busy, done, error}, 3'b000);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        clear_log();
        run_scan("t6b");
        wexp_idx = '{8'h25, 8'h24}; wexp_dat = '{4'h0, 4'h2};
        chk_writes("t6b");
        chk("t6b_map", mem_map, 8'hFF);
        chk("t6b_cnt", board_count, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
